// File: rtl/cellrv32_irq_sched.sv
// Programmable-priority interrupt scheduler: latches per-channel requests, arbitrates by
// priority with round-robin among equals, and drives one CPU line through claim/complete.
module cellrv32_irq_sched #(
    parameter int unsigned NUM_CH    = 16,
    parameter logic [31:0] BASE_ADDR = 32'hFFFFFF00
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [31:0]       addr_i,
    input  logic              rden_i,
    input  logic              wren_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              ack_o,
    input  logic [NUM_CH-1:0] req_i,
    output logic              cpu_irq_o
);

    localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] RegEnable = 2'd0;
    localparam logic [1:0] RegPrio   = 2'd1;
    localparam logic [1:0] RegThresh = 2'd2;
    localparam logic [1:0] RegClaim  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StNotify,
        StService
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cur_id_q, cur_id_d;
    logic [3:0]          rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]   enable_q, enable_d;
    logic [2*NUM_CH-1:0] prio_q, prio_d;
    logic [1:0]          thresh_q, thresh_d;
    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic                irq_q;
    logic                ack_q;
    logic [31:0]         rdata_q, rdata_d;

    logic              acc_sel;
    logic              rd_req;
    logic              wr_req;
    logic [1:0]        reg_sel;
    logic              claim_rd;
    logic              claim_wr;
    logic              claim_grant;
    logic [NUM_CH-1:0] claim_clr;
    logic [NUM_CH-1:0] svc_mask;
    logic [NUM_CH-1:0] elig;
    logic [1:0]        ch_prio [NUM_CH];
    logic [1:0]        max_prio;
    logic              any_elig;
    logic              win_found;
    logic [3:0]        win_id;
    logic [IdxW-1:0]   scan;
    logic              cur_elig;
    logic              unused_addr;

    // Scan position relative to the round-robin pointer, wrapped into the channel range.
    function automatic logic [IdxW-1:0] wrap_idx(input int unsigned v);
        int unsigned w;
        w = (v >= NUM_CH) ? v - NUM_CH : v;
        return IdxW'(w);
    endfunction

    // Bus decode
    assign acc_sel     = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign rd_req      = acc_sel & rden_i;
    assign wr_req      = acc_sel & wren_i;
    assign reg_sel     = addr_i[3:2];
    assign claim_rd    = rd_req & (reg_sel == RegClaim);
    assign claim_wr    = wr_req & (reg_sel == RegClaim);
    assign unused_addr = ^addr_i[1:0];

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        assign ch_prio[g]  = prio_q[2*g +: 2];
        assign elig[g]     = pending_q[g] & enable_q[g] & (ch_prio[g] > thresh_q);
        assign svc_mask[g] = (state_q == StService) && (cur_id_q == 4'(g));
        assign claim_clr[g] = claim_grant && (cur_id_q == 4'(g));
    end

    // Highest eligible priority, then first match scanning upward from rr_ptr.
    always_comb begin
        max_prio  = 2'd0;
        any_elig  = |elig;
        win_found = 1'b0;
        win_id    = 4'd0;
        scan      = '0;
        cur_elig  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (elig[i] && (ch_prio[i] > max_prio)) begin
                max_prio = ch_prio[i];
            end
            if (cur_id_q == 4'(i)) begin
                cur_elig = elig[i];
            end
        end
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            scan = wrap_idx(32'(rr_ptr_q) + k);
            if (!win_found && elig[scan] && (ch_prio[scan] == max_prio)) begin
                win_found = 1'b1;
                win_id    = 4'(scan);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        rr_ptr_d    = rr_ptr_q;
        claim_grant = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_elig) begin
                    cur_id_d = win_id;
                    state_d  = StNotify;
                end
            end
            StNotify: begin
                // Losing eligibility abandons the notification; a read in that cycle gets 0.
                if (!cur_elig) begin
                    state_d = StIdle;
                end else if (claim_rd) begin
                    claim_grant = 1'b1;
                    state_d     = StService;
                    rr_ptr_d    = (cur_id_q == 4'(NUM_CH - 1)) ? 4'd0 : cur_id_q + 4'd1;
                end
            end
            StService: begin
                if (claim_wr && (data_i[3:0] == cur_id_q)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Claim clear wins over a same-cycle set; the in-service channel cannot re-pend.
    assign pending_d = (pending_q | (req_i & enable_q & ~svc_mask)) & ~claim_clr;

    always_comb begin
        enable_d = enable_q;
        prio_d   = prio_q;
        thresh_d = thresh_q;
        if (wr_req) begin
            unique case (reg_sel)
                RegEnable: enable_d = data_i[NUM_CH-1:0];
                RegPrio:   prio_d   = data_i[2*NUM_CH-1:0];
                RegThresh: thresh_d = data_i[1:0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        rdata_d = 32'd0;
        if (rd_req) begin
            unique case (reg_sel)
                RegEnable: rdata_d[NUM_CH-1:0]   = enable_q;
                RegPrio:   rdata_d[2*NUM_CH-1:0] = prio_q;
                RegThresh: rdata_d[1:0]          = thresh_q;
                RegClaim: begin
                    if (claim_grant) begin
                        rdata_d = {1'b1, 27'd0, cur_id_q};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= StIdle;
            cur_id_q  <= 4'd0;
            rr_ptr_q  <= 4'd0;
            enable_q  <= '0;
            prio_q    <= '0;
            thresh_q  <= 2'd0;
            pending_q <= '0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cur_id_q  <= cur_id_d;
            rr_ptr_q  <= rr_ptr_d;
            enable_q  <= enable_d;
            prio_q    <= prio_d;
            thresh_q  <= thresh_d;
            pending_q <= pending_d;
            irq_q     <= (state_q == StNotify);
            ack_q     <= (rden_i | wren_i) & acc_sel;
            rdata_q   <= rdata_d;
        end
    end

    assign cpu_irq_o = irq_q;
    assign ack_o     = ack_q;
    assign data_o    = rdata_q;

endmodule

// File: tb/tb_cellrv32_irq_sched.sv
// Bench for cellrv32_irq_sched: bus responses are scoreboarded by a monitor; directed
// handshake scenarios are followed by randomized rounds against a priority/rotation model.
module tb_cellrv32_irq_sched;

    localparam int unsigned NCH     = 16;
    localparam logic [31:0] BASE    = 32'hFFFFFF00;
    localparam logic [31:0] A_EN    = BASE + 32'h0;
    localparam logic [31:0] A_PRIO  = BASE + 32'h4;
    localparam logic [31:0] A_TH    = BASE + 32'h8;
    localparam logic [31:0] A_CLAIM = BASE + 32'hC;
    localparam logic [31:0] A_OTHER = BASE + 32'h10;

    logic            clk_i = 1'b0;
    logic            rstn_i = 1'b0;
    logic [31:0]     addr_i = '0;
    logic            rden_i = 1'b0;
    logic            wren_i = 1'b0;
    logic [31:0]     data_i = '0;
    logic [31:0]     data_o;
    logic            ack_o;
    logic [NCH-1:0]  req_i = '0;
    logic            cpu_irq_o;

    cellrv32_irq_sched #(
        .NUM_CH   (NCH),
        .BASE_ADDR(BASE)
    ) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .addr_i   (addr_i),
        .rden_i   (rden_i),
        .wren_i   (wren_i),
        .data_i   (data_i),
        .data_o   (data_o),
        .ack_o    (ack_o),
        .req_i    (req_i),
        .cpu_irq_o(cpu_irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] cyc = '0;
    int          checks = 0;
    int          failures = 0;

    // Reference model state for the randomized phase
    logic [NCH-1:0]   m_pend;
    logic [NCH-1:0]   m_en;
    logic [2*NCH-1:0] m_prio;
    logic [1:0]       m_th;
    int               m_rr;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: every ack must match the oldest outstanding access, on the promised cycle.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            checks++;
            if (ack_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack: ack_o=1 data_o=%08h, required no ack", data_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (data_o !== mon_e.data || cyc !== mon_e.cyc) begin
                        failures++;
                        $display("FAIL bus_resp: data_o=%08h at cycle %0d, required %08h at cycle %0d",
                                 data_o, cyc, mon_e.data, mon_e.cyc);
                    end
                end
            end else if (ack_o !== 1'b0 || data_o !== 32'd0) begin
                failures++;
                $display("FAIL idle_bus: ack_o=%b data_o=%08h, required ack_o=0 data_o=0",
                         ack_o, data_o);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp_data);
        exp_q.push_back({exp_data, cyc + 32'd1});
        addr_i = a;
        rden_i = 1'b1;
        tick(1);
        rden_i = 1'b0;
        addr_i = '0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({32'd0, cyc + 32'd1});
        addr_i = a;
        data_i = d;
        wren_i = 1'b1;
        tick(1);
        wren_i = 1'b0;
        addr_i = '0;
        data_i = '0;
    endtask

    // Access outside the register block: no ack may follow.
    task automatic bus_stray(input logic [31:0] d);
        addr_i = A_OTHER;
        data_i = d;
        wren_i = 1'b1;
        rden_i = 1'b1;
        tick(1);
        wren_i = 1'b0;
        rden_i = 1'b0;
        addr_i = '0;
        data_i = '0;
    endtask

    task automatic wait_irq(input logic level, input int bound, input string name);
        int n;
        n = 0;
        while (cpu_irq_o !== level && n < bound) begin
            tick(1);
            n++;
        end
        check(name, {31'd0, cpu_irq_o}, {31'd0, level});
    endtask

    task automatic pulse_req(input logic [NCH-1:0] mask);
        req_i = mask;
        tick(1);
        req_i = '0;
    endtask

    task automatic apply_reset();
        rstn_i = 1'b0;
        req_i  = '0;
        rden_i = 1'b0;
        wren_i = 1'b0;
        tick(2);
        check("reset_irq", {31'd0, cpu_irq_o}, 32'd0);
        check("reset_ack", {31'd0, ack_o}, 32'd0);
        check("reset_data", data_o, 32'd0);
        exp_q.delete();
        rstn_i = 1'b1;
        tick(1);
    endtask

    // Winner: highest priority first, then smallest forward distance from the rotation pointer.
    function automatic int model_pick();
        int best_key;
        int id;
        int p;
        int key;
        best_key = 1 << 30;
        id = -1;
        for (int i = 0; i < NCH; i++) begin
            p = int'(m_prio[2*i +: 2]);
            if (m_pend[i] && m_en[i] && p > int'(m_th)) begin
                key = (3 - p) * NCH + (i - m_rr + NCH) % NCH;
                if (key < best_key) begin
                    best_key = key;
                    id = i;
                end
            end
        end
        return id;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ids[5];
        int id;
        int n;
        logic [NCH-1:0] en;
        logic [NCH-1:0] mask;
        logic [31:0]    pr;
        logic [1:0]     th;

        tick(1);
        // Single channel, basic handshake and latency
        apply_reset();
        bus_rd(A_EN, 32'd0);
        bus_rd(A_PRIO, 32'd0);
        bus_rd(A_TH, 32'd0);
        bus_rd(A_CLAIM, 32'd0);
        bus_wr(A_EN, 32'h1);
        bus_wr(A_PRIO, 32'h1);
        bus_wr(A_TH, 32'h0);
        pulse_req(16'h0001);
        check("t1_irq_n", {31'd0, cpu_irq_o}, 32'd0);
        tick(1);
        check("t1_irq_n1", {31'd0, cpu_irq_o}, 32'd0);
        tick(1);
        check("t1_irq_n2", {31'd0, cpu_irq_o}, 32'd1);
        bus_rd(A_CLAIM, 32'h8000_0000);
        tick(1);
        check("t1_irq_drop", {31'd0, cpu_irq_o}, 32'd0);
        bus_wr(A_CLAIM, 32'h0);
        tick(2);
        bus_rd(A_CLAIM, 32'd0);
        pulse_req(16'h0001);
        wait_irq(1'b1, 6, "t1_irq_again");
        bus_rd(A_CLAIM, 32'h8000_0000);
        bus_wr(A_CLAIM, 32'h0);

        // Priority ordering
        apply_reset();
        bus_wr(A_EN, 32'h0028);
        bus_wr(A_PRIO, (32'd1 << 6) | (32'd3 << 10));
        pulse_req(16'h0028);
        wait_irq(1'b1, 6, "t2_irq1");
        bus_rd(A_CLAIM, 32'h8000_0005);
        bus_wr(A_CLAIM, 32'h5);
        wait_irq(1'b1, 6, "t2_irq2");
        bus_rd(A_CLAIM, 32'h8000_0003);
        bus_wr(A_CLAIM, 32'h3);

        // Round-robin among equal priorities with held requests
        apply_reset();
        req_i = 16'h0016;
        bus_wr(A_EN, 32'h0016);
        bus_wr(A_PRIO, (32'd2 << 2) | (32'd2 << 4) | (32'd2 << 8));
        ids = '{1, 2, 4, 1, 2};
        for (int k = 0; k < 5; k++) begin
            wait_irq(1'b1, 8, "t3_irq");
            bus_rd(A_CLAIM, 32'h8000_0000 | 32'(ids[k]));
            bus_wr(A_CLAIM, 32'(ids[k]));
        end
        req_i = '0;

        // Threshold, priority raise, and withdrawal while notifying
        apply_reset();
        bus_wr(A_TH, 32'h2);
        bus_wr(A_EN, 32'h0080);
        bus_wr(A_PRIO, 32'd2 << 14);
        pulse_req(16'h0080);
        tick(5);
        check("t4_thresh_block", {31'd0, cpu_irq_o}, 32'd0);
        bus_wr(A_PRIO, 32'd3 << 14);
        wait_irq(1'b1, 2, "t4_irq_rise");
        bus_wr(A_EN, 32'h0);
        wait_irq(1'b0, 3, "t4_irq_drop");
        tick(3);
        check("t4_irq_stays_low", {31'd0, cpu_irq_o}, 32'd0);
        bus_rd(A_CLAIM, 32'd0);
        bus_wr(A_EN, 32'h0080);
        wait_irq(1'b1, 6, "t4_still_pending");
        bus_rd(A_CLAIM, 32'h8000_0007);
        bus_wr(A_CLAIM, 32'h7);

        // Mismatched completion, masking in service, asynchronous reset
        apply_reset();
        bus_wr(A_EN, 32'h0004);
        bus_wr(A_PRIO, 32'd1 << 4);
        pulse_req(16'h0004);
        wait_irq(1'b1, 6, "t5_irq");
        bus_rd(A_CLAIM, 32'h8000_0002);
        bus_wr(A_CLAIM, 32'h3);
        req_i = 16'h0004;
        tick(4);
        check("t5_masked", {31'd0, cpu_irq_o}, 32'd0);
        bus_rd(A_CLAIM, 32'd0);
        bus_wr(A_CLAIM, 32'h2);
        wait_irq(1'b1, 6, "t5_repend");
        req_i = '0;
        #2 rstn_i = 1'b0;
        #1;
        check("t5_async_irq", {31'd0, cpu_irq_o}, 32'd0);
        exp_q.delete();
        tick(2);
        rstn_i = 1'b1;
        tick(1);
        tick(6);
        check("t5_quiet", {31'd0, cpu_irq_o}, 32'd0);
        bus_rd(A_EN, 32'd0);
        bus_wr(A_EN, 32'h0004);
        bus_wr(A_PRIO, 32'd1 << 4);
        tick(6);
        check("t5_pending_cleared", {31'd0, cpu_irq_o}, 32'd0);

        // Randomized rounds against the model
        apply_reset();
        m_pend = '0;
        m_en   = '0;
        m_prio = '0;
        m_th   = 2'd0;
        m_rr   = 0;
        for (int r = 0; r < 40; r++) begin
            bus_wr(A_TH, 32'h3);
            en   = NCH'($urandom);
            pr   = $urandom;
            mask = NCH'($urandom);
            th   = 2'($urandom_range(0, 2));
            bus_wr(A_EN, 32'(en));
            bus_wr(A_PRIO, pr);
            m_en   = en;
            m_prio = pr;
            bus_stray($urandom);
            bus_rd(A_EN, 32'(en));
            bus_rd(A_PRIO, pr);
            pulse_req(mask);
            m_pend = m_pend | (mask & en);
            bus_wr(A_TH, ($urandom & 32'hFFFF_FFFC) | 32'(th));
            m_th = th;
            bus_rd(A_TH, 32'(th));
            n = 0;
            id = model_pick();
            while (id >= 0 && n <= NCH) begin
                n++;
                wait_irq(1'b1, 12, "rand_irq_high");
                bus_rd(A_CLAIM, 32'h8000_0000 | 32'(id));
                m_pend[id] = 1'b0;
                m_rr = (id + 1) % NCH;
                if ($urandom_range(0, 3) == 0) begin
                    bus_wr(A_CLAIM, 32'(id ^ 1));
                    bus_rd(A_CLAIM, 32'd0);
                end
                bus_wr(A_CLAIM, 32'(id));
                id = model_pick();
            end
            tick(4);
            check("rand_irq_idle", {31'd0, cpu_irq_o}, 32'd0);
            bus_rd(A_CLAIM, 32'd0);
        end

        tick(3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
